rx: RTL
=======

# rx

UART receiver, 8N1, LSB first; the receive-side counterpart of the team's `tx` transmitter, sharing its `BAUD_DIV` clocks-per-bit convention. It synchronises the asynchronous serial line, validates the start bit at mid-bit, samples 8 data bits and the stop bit at bit centres, and presents each good byte in a holding register with a valid/ack handshake. It sits between the board RX pin and the core's peripheral bus, alongside `tx`.

## Interface
- `BAUD_DIV`, 217: clock cycles per bit; legal range 4..65535. `HALF = BAUD_DIV/2` (integer division).
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rx`  in  1  asynchronous serial line; idles high.
- `i_ack`  in  1  consumer acknowledge; clears `o_valid`.
- `o_data`  out  8  last received byte.
- `o_valid`  out  1  `o_data` holds an unconsumed byte.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `o_overrun`  out  1  sticky: a byte was delivered while the previous one was unconsumed. Cleared only by reset.
- `o_busy`  out  1  high whenever state is not IDLE.

## Operation
- Synchroniser: two flops on `i_rx`, both reset to 1; `rx_s` is the second flop output. All decisions use `rx_s` only.
- Baud counter: 16-bit. Bit index: 0..7. Shift register: 8-bit, right shift, new bit inserted at bit 7.
- States:
  - IDLE: when `rx_s`==0, set counter to 1 and go to START. Otherwise stay.
  - START: at counter==HALF, if `rx_s`==0, set counter to 1, bit index to 0, and go to DATA. If `rx_s`==1 (glitch), go to IDLE with no output. Otherwise increment the counter.
  - DATA: at counter==BAUD_DIV, shift in `rx_s` and set counter to 1. If bit index is 7, go to STOP; otherwise increment the bit index. Otherwise increment the counter.
  - STOP: at counter==BAUD_DIV, sample `rx_s`:
    - If 1: load `o_data` from the shift register, set `o_valid`=1, and go to IDLE.
    - If 0: pulse `o_frame_err`, leave `o_data` and `o_valid` untouched, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. A break condition therefore produces exactly one frame error.
  - Any undefined state code goes to IDLE.
- Handshake:
  - `o_valid` stays 1 until a cycle with `i_ack`=1; it is 0 from the next cycle.
  - `i_ack` while `o_valid`=0 is ignored.
  - New byte delivered while `o_valid`=1 and `i_ack`=0: `o_data` is overwritten, `o_valid` stays 1, and `o_overrun` is set.
  - New byte delivered in the same cycle as `i_ack`=1: the delivery wins, `o_valid` stays 1, `o_data` takes the new byte, and there is no overrun.
- Reset:
  - All outputs reset to 0: `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0, `o_busy`=0.
  - State goes to IDLE.
  - Reset asserted mid-frame abandons the frame; no partial byte is delivered.

## Timing
- Let cycle D be the cycle in which IDLE sees `rx_s`==0. `rx_s` lags `i_rx` by 2 cycles.
- Start check at D+HALF.
- Data bit k (k=0..7) sampled at D+HALF+(k+1)·BAUD_DIV.
- Stop bit sampled at D+HALF+9·BAUD_DIV.
- `o_valid` or `o_frame_err` is high in the following cycle.
- Example, BAUD_DIV=217: bit0 at D+325, stop at D+2061.
- `o_busy` is high from D+1 through the cycle the state returns to IDLE.
- Back-to-back frames: a new start edge is detected in the first IDLE cycle after STOP, so zero idle bits between frames are supported.
- Tolerance: ±4% total clock mismatch with BAUD_DIV≥16.

## Test plan
- BAUD_DIV=16: send 8'hA5 framed 0-[1,0,1,0,0,1,0,1]-1 at exactly 16 cycles/bit -> `o_data`=8'hA5 and `o_valid`=1 at D+153; `o_frame_err`=0, `o_overrun`=0.
- Low pulse of 5 cycles on idle line -> state returns to IDLE at D+8; `o_valid` and `o_frame_err` never assert; the next frame 8'h3C is received correctly.
- Frame 8'h00 with the stop bit held low, then line released 40 cycles later -> single `o_frame_err` pulse at D+153; `o_valid` stays 0; `o_busy` stays high until `rx_s` returns high.
- Back-to-back 8'h11, 8'h22 with no ack -> the second delivery sets `o_overrun`=1 and `o_data`=8'h22; `o_overrun` stays 1 after a later ack and clears only on `i_rst`.
- `i_ack` asserted in the exact cycle the second byte 8'h22 is delivered -> `o_valid` stays 1, `o_data`=8'h22, `o_overrun`=0; a subsequent ack drops `o_valid` the next cycle.
- `i_rst` pulsed at D+70 during 8'hFF -> all outputs 0 next cycle; no delivery; the following frame 8'h5A is received correctly.

Source files
------------

// File: rtl/rx.sv
// UART receiver, 8N1, LSB first, BAUD_DIV clocks per bit.
// Two-flop synchroniser, mid-bit start validation, centre sampling, valid/ack holding register.
module rx #(
    parameter int BAUD_DIV = 217
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy,
    output logic [2:0] o_state
);

    localparam logic [15:0] DIV  = 16'(BAUD_DIV);
    localparam logic [15:0] HALF = 16'(BAUD_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  idx;
    logic [2:0]  idx_n;
    logic [7:0]  sh;
    logic [7:0]  sh_n;
    logic        deliver;
    logic        ferr;
    logic        sync1;
    logic        rx_s;

    // Both synchroniser flops reset to the idle (high) level so reset never fakes a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_rx;
            rx_s  <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = 16'd1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF) begin
                    if (!rx_s) begin
                        cnt_n   = 16'd1;
                        idx_n   = 3'd0;
                        state_n = S_DATA;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == DIV) begin
                    sh_n  = {rx_s, sh[7:1]};
                    cnt_n = 16'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt == DIV) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            // A held-low line (break) yields one frame error, then waits here for idle.
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Handshake: o_valid rises on delivery and falls the cycle after i_ack; a delivery in
    // the same cycle as i_ack wins, and a delivery onto an unacked byte sets o_overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            idx         <= 3'd0;
            sh          <= 8'h00;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            sh          <= sh_n;
            o_frame_err <= ferr;
            if (deliver) begin
                o_data  <= sh;
                o_valid <= 1'b1;
                if (o_valid && !i_ack) begin
                    o_overrun <= 1'b1;
                end
            end else if (i_ack) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy  = (state != S_IDLE);
    assign o_state = state;

endmodule
